npu_cmd_ctrl: RTL and testbench
===============================

# npu_cmd_ctrl

Command sequencer between the SPI slave byte interface and the NPU compute core inside `top_npu_system`. It decodes SPI frames into buffer writes, compute launches, result readback and status queries. It tracks core completion with a watchdog and drives the system-level `done` flag. It runs entirely in the 100 MHz core clock domain; CS edges arrive as synchronized pulses.

## Interface
- `ADDR_W`, 8: buffer/result address width; address space is 2^ADDR_W bytes.
- `TIMEOUT_W`, 16: watchdog counter width.
- `clk` in 1: core clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `frame_start` in 1: one-cycle pulse on synchronized CS assert.
- `frame_end` in 1: one-cycle pulse on synchronized CS deassert.
- `rx_valid` in 1: one-cycle pulse; `rx_byte` holds a received byte.
- `rx_byte` in 8: received byte.
- `tx_load` out 1: one-cycle pulse; SPI slave latches `tx_byte` for the next shifted byte.
- `tx_byte` out 8: byte to return.
- `mem_we` out 1: buffer write strobe.
- `mem_sel` out 1: target buffer, 0 = weight, 1 = input.
- `mem_addr` out ADDR_W: buffer write address.
- `mem_wdata` out 8: buffer write data.
- `res_re` out 1: result read strobe.
- `res_addr` out ADDR_W: result read address.
- `res_rdata` in 8: result data, valid exactly 1 cycle after `res_re`.
- `core_start` out 1: one-cycle launch pulse.
- `core_done` in 1: one-cycle completion pulse.
- `done` out 1: level; last launch completed without timeout.
- `err` out 1: sticky error; cleared only by reset or a STATUS read.

## Operation
- **Opcodes** (first byte of a frame):
  - 0x01 WR_W, 0x02 WR_X: second byte is the start address. Each following byte produces one write (`mem_we`=1, `mem_sel` per opcode, data = byte), then the address increments. The address wraps from 2^ADDR_W−1 to 0.
  - 0x03 START: if not busy, pulse `core_start`, set busy, clear `done`, load the watchdog. If busy, set `err` and do not launch.
  - 0x04 RD_R: second byte is the start address. The block issues `res_re`, then `tx_load` with `res_rdata`. Each later `rx_valid` (dummy byte) increments the address (same wrap rule) and fetches and loads the next byte.
  - 0x05 STATUS: immediately pulses `tx_load` with `tx_byte` = {5'b0, err, done, busy}, then clears `err`.
  - Any other opcode: set `err`, ignore bytes until `frame_end`.
- **FSM states:**
  - IDLE→OPCODE on `frame_start`.
  - OPCODE→ADDR (0x01/0x02/0x04), →DRAIN (0x03/0x05/illegal).
  - ADDR→WRITE or RD_FETCH.
  - RD_FETCH→RD_LOAD→RD_WAIT. RD_WAIT→RD_FETCH on `rx_valid`.
  - Any state→IDLE on `frame_end`. Any state→OPCODE on `frame_start`.
- **Boundary rules:**
  - `rx_valid` and `frame_end` in the same cycle: the byte is processed first, then the FSM goes to IDLE.
  - `frame_start` mid-frame: the current command is aborted with no error.
  - Bytes arriving in IDLE are ignored.
  - The watchdog decrements while busy. On reaching 0: set `err`, clear busy, leave `done`=0.
  - `core_done` while busy: clear busy, set `done`. `core_done` while not busy is ignored.
  - START and `core_done` in the same cycle: `core_done` is processed first, so the launch is accepted.
- **Reset values:** all outputs 0. State IDLE, busy 0, watchdog 0, internal address 0.

## Timing
- WR_W/WR_X: `mem_we` is asserted the cycle after the data-byte `rx_valid`.
- RD_R: `res_re` is asserted the cycle after the address byte or dummy byte. `tx_load` follows 2 cycles after that `rx_valid`.
- STATUS: `tx_load` is asserted the cycle after the opcode byte.
- START: `core_start` is asserted the cycle after the opcode byte.
- Watchdog: loaded with 2^TIMEOUT_W−1 on launch, expires that many cycles later.
- Throughput: every state takes ≤3 cycles per byte. This is well under one SPI byte time.

## Structure
- **`npu_pkg`:**
  - opcode localparams (OP_WR_W, OP_WR_X, OP_START, OP_RD_R, OP_STATUS)
  - FSM state enum
  - status byte bit positions
- **Sub-module `npu_watchdog`:** loadable down-counter with `load`, `clear` and `expire` pulse, parameterized by TIMEOUT_W.

## Test plan
- **Weight write with wrap:** frame 0x01, 0xFE, 0xAA, 0xBB, 0xCC → writes weight[0xFE]=0xAA, [0xFF]=0xBB, [0x00]=0xCC, `mem_sel`=0.
- **Launch and complete:** frame 0x03; `core_done` 50 cycles later → one `core_start` pulse, then `done`=1. A following STATUS frame returns 0x02.
- **Double START:** START, then START again while busy → only one `core_start`, `err`=1. STATUS returns 0x05, and a second STATUS returns 0x01.
- **Result readback:** preload result[3]=0x11, [4]=0x22; frame 0x04, 0x03, dummy, dummy → `tx_byte` sequence 0x11, 0x22, 0x33 with result[5]=0x33.
- **Watchdog timeout:** TIMEOUT_W=4; START with no `core_done` → `err`=1 and busy=0 after 15 cycles, `done`=0.
- **Illegal opcode and abort:** frame 0x7F, 0x01 → `err`=1 and no write occurs. A WR_X frame cut by `frame_start` after the address byte performs no write, and the new frame then decodes normally.

Source files
------------

// File: rtl/npu_pkg.sv
// npu_pkg: opcodes, sequencer states and status-byte layout
// shared by the NPU command controller slice.
package npu_pkg;

  localparam logic [7:0] OP_WR_W   = 8'h01;
  localparam logic [7:0] OP_WR_X   = 8'h02;
  localparam logic [7:0] OP_START  = 8'h03;
  localparam logic [7:0] OP_RD_R   = 8'h04;
  localparam logic [7:0] OP_STATUS = 8'h05;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPCODE,
    S_ADDR,
    S_WRITE,
    S_RD_FETCH,
    S_RD_LOAD,
    S_RD_WAIT,
    S_DRAIN
  } state_t;

  function automatic logic op_legal(input logic [7:0] op);
    return op inside {OP_WR_W, OP_WR_X, OP_START,
                      OP_RD_R, OP_STATUS};
  endfunction

endpackage

// File: rtl/npu_cmd_ctrl_if.sv
// npu_cmd_ctrl_if: SPI byte stream, buffer/result ports and
// core launch handshake between the sequencer and its peers.
interface npu_cmd_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              frame_start;
  logic              frame_end;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              tx_load;
  logic [7:0]        tx_byte;
  logic              mem_we;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              res_re;
  logic [ADDR_W-1:0] res_addr;
  logic [7:0]        res_rdata;
  logic              core_start;
  logic              core_done;

  modport master (
    input  frame_start, frame_end, rx_valid, rx_byte,
    input  res_rdata, core_done,
    output tx_load, tx_byte,
    output mem_we, mem_sel, mem_addr, mem_wdata,
    output res_re, res_addr, core_start
  );

  modport slave (
    output frame_start, frame_end, rx_valid, rx_byte,
    output res_rdata, core_done,
    input  tx_load, tx_byte,
    input  mem_we, mem_sel, mem_addr, mem_wdata,
    input  res_re, res_addr, core_start
  );
endinterface

// File: rtl/npu_watchdog.sv
// npu_watchdog: loadable down-counter; expire pulses on the
// last count so the owner sees it one cycle before zero.
module npu_watchdog #(
  parameter int TIMEOUT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clear,
  output logic expire
);
  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '1;
    end else if (clear) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == TIMEOUT_W'(1));

endmodule

// File: rtl/npu_cmd_ctrl.sv
// npu_cmd_ctrl: decodes SPI frames into buffer writes, core
// launches, result readback and status queries.
module npu_cmd_ctrl
  import npu_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  npu_cmd_ctrl_if.master bus,
  output logic           done,
  output logic           err
);
  state_t            state;
  logic [7:0]        op_q;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_nx;
  logic              busy;
  logic              tx_src;
  logic [7:0]        tx_stat;
  logic [7:0]        stat;
  logic              byte_in;
  logic              op_byte;
  logic              done_ok;
  logic              launch;
  logic              start_rej;
  logic              status_cmd;
  logic              bad_cmd;
  logic              wd_expire;
  logic              expire_ok;

  // a new frame_start discards any byte of the aborted frame
  assign byte_in    = bus.rx_valid && !bus.frame_start;
  assign op_byte    = byte_in && (state == S_OPCODE);
  assign done_ok    = bus.core_done && busy;
  assign launch     = op_byte && (bus.rx_byte == OP_START)
                      && (!busy || bus.core_done);
  assign start_rej  = op_byte && (bus.rx_byte == OP_START)
                      && busy && !bus.core_done;
  assign status_cmd = op_byte && (bus.rx_byte == OP_STATUS);
  assign bad_cmd    = op_byte && !op_legal(bus.rx_byte);
  assign expire_ok  = wd_expire && !bus.core_done;
  assign addr_nx    = addr + 1'b1;

  always_comb begin
    stat          = '0;
    stat[ST_BUSY] = busy;
    stat[ST_DONE] = done;
    stat[ST_ERR]  = err;
  end

  // readback data arrives the same cycle as tx_load
  assign bus.tx_byte = tx_src ? bus.res_rdata : tx_stat;

  npu_watchdog #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_wd (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (launch),
    .clear (done_ok),
    .expire(wd_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      if (launch) begin
        busy <= 1'b1;
      end else if (done_ok || expire_ok) begin
        busy <= 1'b0;
      end
      if (launch) begin
        done <= 1'b0;
      end else if (done_ok) begin
        done <= 1'b1;
      end
      if (start_rej || bad_cmd || expire_ok) begin
        err <= 1'b1;
      end else if (status_cmd) begin
        err <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      op_q           <= '0;
      addr           <= '0;
      tx_src         <= 1'b0;
      tx_stat        <= '0;
      bus.tx_load    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_sel    <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.res_re     <= 1'b0;
      bus.res_addr   <= '0;
      bus.core_start <= 1'b0;
    end else begin
      bus.mem_we     <= 1'b0;
      bus.res_re     <= 1'b0;
      bus.tx_load    <= 1'b0;
      bus.core_start <= launch;
      unique case (state)
        S_OPCODE: if (byte_in) begin
          op_q <= bus.rx_byte;
          unique case (1'b1)
            (bus.rx_byte == OP_WR_W),
            (bus.rx_byte == OP_WR_X),
            (bus.rx_byte == OP_RD_R): state <= S_ADDR;
            (bus.rx_byte == OP_STATUS): begin
              tx_src      <= 1'b0;
              tx_stat     <= stat;
              bus.tx_load <= 1'b1;
              state       <= S_DRAIN;
            end
            default: state <= S_DRAIN;
          endcase
        end
        S_ADDR: if (byte_in) begin
          addr <= bus.rx_byte[ADDR_W-1:0];
          if (op_q == OP_RD_R) begin
            bus.res_re   <= 1'b1;
            bus.res_addr <= bus.rx_byte[ADDR_W-1:0];
            state        <= S_RD_FETCH;
          end else begin
            state <= S_WRITE;
          end
        end
        S_WRITE: if (byte_in) begin
          bus.mem_we    <= 1'b1;
          bus.mem_sel   <= (op_q == OP_WR_X);
          bus.mem_addr  <= addr;
          bus.mem_wdata <= bus.rx_byte;
          addr          <= addr_nx;
        end
        S_RD_FETCH: begin
          tx_src      <= 1'b1;
          bus.tx_load <= 1'b1;
          state       <= S_RD_LOAD;
        end
        S_RD_LOAD: state <= S_RD_WAIT;
        S_RD_WAIT: if (byte_in) begin
          addr         <= addr_nx;
          bus.res_addr <= addr_nx;
          bus.res_re   <= 1'b1;
          state        <= S_RD_FETCH;
        end
        default: ;
      endcase
      if (bus.frame_end) state <= S_IDLE;
      if (bus.frame_start) state <= S_OPCODE;
    end
  end

endmodule

// File: tb/tb_npu_cmd_ctrl.sv
// tb_npu_cmd_ctrl: frame-level reference model feeding write,
// tx and launch scoreboards checked by a negedge monitor.
module tb_npu_cmd_ctrl;
  import npu_pkg::*;

  localparam int AW  = 8;
  localparam int TW  = 6;
  localparam int TMO = (1 << TW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic done;
  logic err;
  logic [7:0] rdata_q = '0;

  npu_cmd_ctrl_if #(.ADDR_W(AW)) bus ();

  npu_cmd_ctrl #(
    .ADDR_W   (AW),
    .TIMEOUT_W(TW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts_seen = 0;
  int exp_starts = 0;

  logic [7:0]  res_mem [256];
  logic [16:0] wq[$];
  logic [7:0]  tq[$];
  logic [7:0]  wdat[$];
  logic [16:0] w_exp;
  logic [7:0]  t_exp;

  bit m_busy = 0;
  bit m_done = 0;
  bit m_err  = 0;
  int m_launch = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (bus.res_re) rdata_q <= res_mem[bus.res_addr];
  assign bus.res_rdata = rdata_q;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (bus.mem_we) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got sel%0d 0x%0h=0x%0h",
                 bus.mem_sel, bus.mem_addr, bus.mem_wdata);
      end else begin
        w_exp = wq.pop_front();
        chk("mem_write",
            32'({bus.mem_sel, bus.mem_addr, bus.mem_wdata}),
            32'(w_exp));
      end
    end
    if (bus.tx_load) begin
      if (tq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx: got 0x%0h", bus.tx_byte);
      end else begin
        t_exp = tq.pop_front();
        chk("tx_byte", 32'(bus.tx_byte), 32'(t_exp));
      end
    end
    if (bus.core_start) starts_seen++;
  end

  // expiry: busy drops TMO cycles after an unanswered launch
  task automatic model_tick();
    if (m_busy && (cyc - m_launch) > TMO) begin
      m_busy = 0;
      m_err  = 1;
    end
  endtask

  task automatic pulse_fs();
    @(negedge clk); bus.frame_start = 1'b1;
    @(negedge clk); bus.frame_start = 1'b0;
  endtask

  task automatic pulse_fe();
    @(negedge clk); bus.frame_end = 1'b1;
    @(negedge clk); bus.frame_end = 1'b0;
  endtask

  task automatic put(input logic [7:0] b, input bit fe);
    @(negedge clk);
    bus.rx_valid  = 1'b1;
    bus.rx_byte   = b;
    bus.frame_end = fe;
    @(negedge clk);
    bus.rx_valid  = 1'b0;
    bus.frame_end = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wr_frame(input bit x, input logic [7:0] a,
                          input bit end_last);
    int n;
    n = wdat.size();
    pulse_fs();
    put(x ? OP_WR_X : OP_WR_W, 0);
    put(a, 0);
    for (int i = 0; i < n; i++) begin
      wq.push_back({x, 8'((a + i) % 256), wdat[i]});
      put(wdat[i], end_last && (i == n - 1));
    end
    if (!end_last) pulse_fe();
  endtask

  task automatic fr_read(input logic [7:0] a, input int n);
    pulse_fs();
    put(OP_RD_R, 0);
    tq.push_back(res_mem[a]);
    put(a, 0);
    for (int i = 1; i <= n; i++) begin
      tq.push_back(res_mem[8'((a + i) % 256)]);
      put(8'($urandom), 0);
    end
    pulse_fe();
  endtask

  task automatic fr_status();
    pulse_fs();
    model_tick();
    tq.push_back({5'b0, m_err, m_done, m_busy});
    m_err = 0;
    put(OP_STATUS, 0);
    pulse_fe();
  endtask

  task automatic fr_start();
    pulse_fs();
    model_tick();
    if (m_busy) begin
      m_err = 1;
    end else begin
      m_busy = 1;
      m_done = 0;
      m_launch = cyc;
      exp_starts++;
    end
    put(OP_START, 0);
    pulse_fe();
  endtask

  task automatic done_pulse();
    model_tick();
    if (m_busy) begin
      m_busy = 0;
      m_done = 1;
    end
    @(negedge clk); bus.core_done = 1'b1;
    @(negedge clk); bus.core_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_levels(input string tag);
    model_tick();
    chk({tag, "_done"}, 32'(done), 32'(m_done));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
  endtask

  initial begin
    #600000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] op;
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.rx_valid    = 1'b0;
    bus.rx_byte     = '0;
    bus.core_done   = 1'b0;
    for (int i = 0; i < 256; i++) res_mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_tx_load", 32'(bus.tx_load), 0);
    chk("rst_core_start", 32'(bus.core_start), 0);
    chk("rst_res_re", 32'(bus.res_re), 0);
    chk("rst_tx_byte", 32'(bus.tx_byte), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // weight write wrapping past the top of the address space
    wdat.delete();
    wdat.push_back(8'hAA);
    wdat.push_back(8'hBB);
    wdat.push_back(8'hCC);
    wr_frame(0, 8'hFE, 0);
    chk("wrap_drained", 32'(wq.size()), 0);

    // launch then complete
    fr_start();
    repeat (35) @(negedge clk);
    done_pulse();
    chk_levels("launch");
    chk("launch_starts", 32'(starts_seen), 32'(exp_starts));
    fr_status();

    // second START while busy is rejected
    fr_start();
    fr_start();
    chk("dbl_starts", 32'(starts_seen), 32'(exp_starts));
    fr_status();
    fr_status();
    done_pulse();
    chk_levels("dbl");

    // START coinciding with core_done still launches
    fr_start();
    repeat (8) @(negedge clk);
    pulse_fs();
    m_busy = 0;
    m_done = 0;
    m_busy = 1;
    m_launch = cyc;
    exp_starts++;
    @(negedge clk);
    bus.rx_valid  = 1'b1;
    bus.rx_byte   = OP_START;
    bus.core_done = 1'b1;
    @(negedge clk);
    bus.rx_valid  = 1'b0;
    bus.core_done = 1'b0;
    repeat (3) @(negedge clk);
    pulse_fe();
    chk("same_cyc_starts", 32'(starts_seen), 32'(exp_starts));
    fr_status();
    done_pulse();
    chk_levels("same_cyc");

    // result readback
    res_mem[3] = 8'h11;
    res_mem[4] = 8'h22;
    res_mem[5] = 8'h33;
    fr_read(8'h03, 2);
    chk("rd_drained", 32'(tq.size()), 0);

    // watchdog expiry with no core_done
    fr_status();
    pulse_fs();
    exp_starts++;
    m_done = 0;
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = OP_START;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("wd_core_start", 32'(bus.core_start), 1);
    repeat (TMO - 1) @(negedge clk);
    chk("wd_err_before", 32'(err), 0);
    @(negedge clk);
    chk("wd_err_after", 32'(err), 1);
    chk("wd_done", 32'(done), 0);
    m_busy = 0;
    m_err  = 1;
    pulse_fe();
    fr_status();
    done_pulse();
    chk_levels("wd_idle_done");

    // illegal opcode ignores the rest of its frame
    pulse_fs();
    put(8'h7F, 0);
    put(8'h01, 0);
    pulse_fe();
    m_err = 1;
    chk_levels("illegal");
    fr_status();

    // abort mid-frame, then a clean frame
    pulse_fs();
    put(OP_WR_X, 0);
    put(8'h10, 0);
    wdat.delete();
    wdat.push_back(8'h5A);
    wr_frame(1, 8'h20, 0);
    chk_levels("abort");

    // bytes outside a frame are ignored
    put(OP_WR_W, 0);
    put(8'h00, 0);
    put(8'h77, 0);
    chk("idle_drained", 32'(wq.size()), 0);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          wdat.delete();
          for (int j = 0; j < int'($urandom_range(1, 5)); j++)
            wdat.push_back(8'($urandom));
          wr_frame(1'($urandom), 8'($urandom),
                   1'($urandom));
        end
        2: fr_read(8'($urandom), int'($urandom_range(0, 3)));
        3: fr_status();
        4: begin
          fr_start();
          repeat ($urandom_range(5, 30)) @(negedge clk);
          done_pulse();
          chk_levels("rnd_launch");
        end
        default: begin
          op = 8'($urandom_range(0, 250));
          if (op != 0) op = op + 8'd5;
          pulse_fs();
          put(op, 0);
          put(8'($urandom), 0);
          pulse_fe();
          m_err = 1;
        end
      endcase
    end

    repeat (10) @(negedge clk);
    chk_levels("final");
    chk("final_wq", 32'(wq.size()), 0);
    chk("final_tq", 32'(tq.size()), 0);
    chk("final_starts", 32'(starts_seen), 32'(exp_starts));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
